// File: rtl/pwm_capture.sv
// pwm_capture: measures active time and period of an asynchronous PWM input on mclk.
// Optional glitch filter enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1000,
  parameter int ACTIVE_LOW = 1,
  parameter int FILT_LEN   = 4
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             stuck_o,
  output logic             stuck_level_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_STUCK = 2'd3
  } state_e;

  localparam logic             INACT_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TMO_C     = TIMEOUT[CNT_W-1:0];

  if (TIMEOUT < 2 || longint'(TIMEOUT) > ((longint'(1) << CNT_W) - 64'sd1)) begin : g_chk_timeout
    $error("pwm_capture: TIMEOUT out of range");
  end
  if (FILT_LEN < 2) begin : g_chk_filt
    $error("pwm_capture: FILT_LEN must be at least 2");
  end

  logic             sync1_q, sync2_q, prev_q;
  logic             act_s, act_f_s, start_s, end_s, timeout_s;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d, high_lat_q, high_lat_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic             valid_q, valid_d, stuck_q, stuck_d, stuck_lvl_q, stuck_lvl_d;
  state_e           state_q, state_d;

  assign act_s = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FC_W = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
  localparam logic [FC_W-1:0] FC_LAST_C = FC_W'(FILT_LEN - 1);

  logic            filt_q, filt_d;
  logic [FC_W-1:0] filt_cnt_q, filt_cnt_d;

  // New level must be seen FILT_LEN consecutive cycles before the output follows.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = filt_cnt_q;
    if (act_s != filt_q) begin
      if (filt_cnt_q == FC_LAST_C) begin
        filt_d     = act_s;
        filt_cnt_d = {FC_W{1'b0}};
      end else begin
        filt_cnt_d = filt_cnt_q + {{(FC_W-1){1'b0}}, 1'b1};
      end
    end else begin
      filt_cnt_d = {FC_W{1'b0}};
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q     <= 1'b0;
      filt_cnt_q <= {FC_W{1'b0}};
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign act_f_s = filt_q;
`else
  assign act_f_s = act_s;
`endif

  assign start_s   = act_f_s & ~prev_q;
  assign end_s     = ~act_f_s & prev_q;
  assign timeout_s = (run_cnt_q == TMO_C);
  assign run_cnt_d = start_s ? ONE_C :
                     ((run_cnt_q == CNT_MAX_C) ? run_cnt_q : run_cnt_q + ONE_C);
  assign high_lat_d = end_s ? run_cnt_q : high_lat_q;

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    high_d      = high_q;
    valid_d     = 1'b0;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_HIGH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH, ST_LOW: begin
        if (state_q == ST_LOW && start_s) begin
          state_d  = ST_HIGH;
          period_d = run_cnt_q;
          high_d   = high_lat_q;
          valid_d  = 1'b1;
        end else if (state_q == ST_HIGH && end_s) begin
          state_d = ST_LOW;
        end else if (!start_s && !end_s && timeout_s) begin
          // An edge in the same cycle takes precedence over the timeout.
          state_d     = ST_STUCK;
          stuck_d     = 1'b1;
          stuck_lvl_d = act_f_s;
          period_d    = ZERO_C;
          high_d      = ZERO_C;
          valid_d     = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_STUCK: begin
        if (start_s) begin
          state_d = ST_HIGH;
          stuck_d = 1'b0;
        end else if (end_s) begin
          state_d = ST_IDLE;
          stuck_d = 1'b0;
        end else begin
          state_d = ST_STUCK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= INACT_RAW;
      sync2_q     <= INACT_RAW;
      prev_q      <= 1'b0;
      run_cnt_q   <= ZERO_C;
      high_lat_q  <= ZERO_C;
      state_q     <= ST_IDLE;
      period_q    <= ZERO_C;
      high_q      <= ZERO_C;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
    end else begin
      sync1_q     <= pwm_in;
      sync2_q     <= sync1_q;
      prev_q      <= act_f_s;
      run_cnt_q   <= run_cnt_d;
      high_lat_q  <= high_lat_d;
      state_q     <= state_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
    end
  end

  assign period_o      = period_q;
  assign high_o        = high_q;
  assign valid_o       = valid_q;
  assign stuck_o       = stuck_q;
  assign stuck_level_o = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: two instances (active-high and active-low) see the same
// logical waveform; a segment-level model pushes expected strobes to a queue.
module tb_pwm_capture;

  localparam int CNT_W    = 16;
  localparam int TIMEOUT  = 1000;
  localparam int FILT_LEN = 4;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = 3 + FILT_LEN;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    int period;
    int high;
    bit stuck;
    bit lvl;
    int cyc;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             pwm_a, pwm_b;
  logic [CNT_W-1:0] period_a, high_a, period_b, high_b;
  logic             valid_a, stuck_a, lvl_a, valid_b, stuck_b, lvl_b;

  int   cyc;
  int   n_total;
  int   n_bad;
  exp_t exp_q[$];

  // model state: 0 idle, 1 running, 2 stuck
  int   m_state;
  bit   m_level;
  bit   m_lvl;
  int   m_start;
  int   m_high;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .ACTIVE_LOW(0), .FILT_LEN(FILT_LEN)) dut_a (
    .mclk(clk), .rst_n(rst_n), .pwm_in(pwm_a),
    .period_o(period_a), .high_o(high_a), .valid_o(valid_a),
    .stuck_o(stuck_a), .stuck_level_o(lvl_a)
  );

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .ACTIVE_LOW(1), .FILT_LEN(FILT_LEN)) dut_b (
    .mclk(clk), .rst_n(rst_n), .pwm_in(pwm_b),
    .period_o(period_b), .high_o(high_b), .valid_o(valid_b),
    .stuck_o(stuck_b), .stuck_level_o(lvl_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic push_exp(input int p, input int h, input bit s, input bit l);
    exp_t e;
    e.period = p;
    e.high   = h;
    e.stuck  = s;
    e.lvl    = l;
    e.cyc    = cyc + LAT;
    exp_q.push_back(e);
  endtask

  // Drive one constant-level segment of the active waveform and update the model.
  task automatic seg(input bit a, input int len);
    bit eff;
    eff = (a != m_level);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    if (len < FILT_LEN) eff = 1'b0;
`endif
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) begin
        pwm_a = a;
        pwm_b = ~a;
      end
      if (i == 0 && eff) begin
        m_level = a;
        if (a) begin
          if (m_state == 1) push_exp(cyc - m_start, m_high, 1'b0, m_lvl);
          m_state = 1;
          m_start = cyc;
        end else begin
          if (m_state == 1) m_high = cyc - m_start;
          else if (m_state == 2) m_state = 0;
        end
      end else if (m_state == 1 && (cyc - m_start) == TIMEOUT) begin
        m_lvl = m_level;
        push_exp(0, 0, 1'b1, m_lvl);
        m_state = 2;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_per_a"}, 32'(period_a), 32'd0);
    check_eq({tag, "_high_a"}, 32'(high_a), 32'd0);
    check_eq({tag, "_valid_a"}, 32'(valid_a), 32'd0);
    check_eq({tag, "_stuck_a"}, 32'(stuck_a), 32'd0);
    check_eq({tag, "_lvl_a"}, 32'(lvl_a), 32'd0);
    check_eq({tag, "_per_b"}, 32'(period_b), 32'd0);
    check_eq({tag, "_high_b"}, 32'(high_b), 32'd0);
    check_eq({tag, "_valid_b"}, 32'(valid_b), 32'd0);
    check_eq({tag, "_stuck_b"}, 32'(stuck_b), 32'd0);
    check_eq({tag, "_lvl_b"}, 32'(lvl_b), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && (valid_a || valid_b)) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'(valid_a | valid_b), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("valid_a", 32'(valid_a), 32'd1);
        check_eq("valid_b", 32'(valid_b), 32'd1);
        check_eq("strobe_cycle", 32'(cyc), 32'(e.cyc));
        check_eq("period_a", 32'(period_a), 32'(e.period));
        check_eq("high_a", 32'(high_a), 32'(e.high));
        check_eq("stuck_a", 32'(stuck_a), 32'(e.stuck));
        check_eq("stuck_lvl_a", 32'(lvl_a), 32'(e.lvl));
        check_eq("period_b", 32'(period_b), 32'(e.period));
        check_eq("high_b", 32'(high_b), 32'(e.high));
        check_eq("stuck_b", 32'(stuck_b), 32'(e.stuck));
        check_eq("stuck_lvl_b", 32'(lvl_b), 32'(e.lvl));
      end
    end
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    pwm_a   = 1'b0;
    pwm_b   = 1'b1;
    m_state = 0;
    m_level = 1'b0;
    m_lvl   = 1'b0;
    m_start = 0;
    m_high  = 0;

    repeat (4) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 50/150: first start publishes nothing, then 200/50
    for (int k = 0; k < 4; k++) begin
      seg(1'b1, 50);
      seg(1'b0, 150);
    end

    // 30/70 (active-low instance sees pwm low for 30 cycles)
    for (int k = 0; k < 4; k++) begin
      seg(1'b1, 30);
      seg(1'b0, 70);
    end

    // hold active past the timeout, release, restart 20/80
    seg(1'b1, 1100);
    check_eq("stuck_hold_a", 32'(stuck_a), 32'd1);
    check_eq("stuck_hold_b", 32'(stuck_b), 32'd1);
    seg(1'b0, 50);
    check_eq("stuck_clear_a", 32'(stuck_a), 32'd0);
    check_eq("stuck_clear_b", 32'(stuck_b), 32'd0);
    for (int k = 0; k < 3; k++) begin
      seg(1'b1, 20);
      seg(1'b0, 80);
    end

    // reset in the middle of an active phase
    seg(1'b1, 10);
    seg(1'b0, 10);
    seg(1'b1, 10);
    seg(1'b0, 10);
    seg(1'b1, 5);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("midrst");
    pwm_a = 1'b0;
    pwm_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    m_state = 0;
    m_level = 1'b0;
    m_lvl   = 1'b0;
    m_high  = 0;
    for (int k = 0; k < 4; k++) begin
      seg(1'b1, 10);
      seg(1'b0, 10);
    end

`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    // minimum waveform 1/1
    for (int k = 0; k < 8; k++) begin
      seg(1'b1, 1);
      seg(1'b0, 1);
    end
    seg(1'b0, 10);
`endif

    // 60/140 with a 2-cycle active glitch inside the inactive phase
    for (int k = 0; k < 5; k++) begin
      seg(1'b1, 60);
      seg(1'b0, 40);
      seg(1'b1, 2);
      seg(1'b0, 98);
    end
    seg(1'b1, 60);
    seg(1'b0, 20);

    check_eq("pending_strobes", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
